// File: rtl/jzjpcc_pkg.sv
// Shared types for the jzjpcc RV32I pipeline: ALU encodings, operand-mux modes
// and the execute->memory pipeline register layout.
package jzjpcc_pkg;

    typedef enum logic [2:0] {
        ADD  = 3'b000,
        SLL  = 3'b001,
        SLT  = 3'b010,
        SLTU = 3'b011,
        XOR  = 3'b100,
        SRL  = 3'b101,
        OR   = 3'b110,
        AND  = 3'b111
    } aluOp_t;

    typedef enum logic [1:0] {
        RS1_RS2  = 2'b00,
        RS1_IMM  = 2'b01,
        PC_IMM   = 2'b10,
        ZERO_IMM = 2'b11
    } aluMuxMode_t;

    localparam logic RD_SRC_ALU = 1'b0;
    localparam logic RD_SRC_MEM = 1'b1;

    typedef struct packed {
        logic        rdWriteEnable;
        logic        memoryWriteEnable;
        logic        rdSource;
        logic [4:0]  rdAddr;
        logic [2:0]  funct3;
        logic [31:0] aluResult;
        logic [31:0] storeData;
    } exMem_t;

    // Memory stage is younger than writeback, so it wins; x0 and loads never forward.
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  addr,
        input logic [31:0] rfVal,
        input logic        memWe,
        input logic [4:0]  memRd,
        input logic        memSrc,
        input logic [31:0] memVal,
        input logic        wbWe,
        input logic [4:0]  wbRd,
        input logic [31:0] wbVal
    );
        if (memWe && (memRd == addr) && (addr != 5'd0) && (memSrc == RD_SRC_ALU))
            return memVal;
        else if (wbWe && (wbRd == addr) && (addr != 5'd0))
            return wbVal;
        else
            return rfVal;
    endfunction

endpackage

// File: rtl/jzjpcc_execute_if.sv
// Decode->execute pipeline register as seen by the execute stage.
interface jzjpcc_execute_if #(parameter int PC_MAX_B = 15);
    logic                rdWriteEnable;
    logic                memoryWriteEnable;
    logic                rdSource;
    logic [4:0]          rdAddr;
    logic [2:0]          funct3;
    logic [4:0]          rs1Addr;
    logic [4:0]          rs2Addr;
    logic [31:0]         rs1;
    logic [31:0]         rs2;
    logic [31:0]         imm;
    logic [1:0]          aluMuxMode;
    logic [2:0]          aluOperation;
    logic                aluMod;
    logic [PC_MAX_B:2]   currentPC;

    modport decode (output rdWriteEnable, memoryWriteEnable, rdSource, rdAddr, funct3,
                    rs1Addr, rs2Addr, rs1, rs2, imm, aluMuxMode, aluOperation, aluMod, currentPC);
    modport execute (input rdWriteEnable, memoryWriteEnable, rdSource, rdAddr, funct3,
                     rs1Addr, rs2Addr, rs1, rs2, imm, aluMuxMode, aluOperation, aluMod, currentPC);
endinterface

// File: rtl/jzjpcc_memory_if.sv
// Execute->memory pipeline register; driven by execute, consumed by memory.
interface jzjpcc_memory_if;
    logic        rdWriteEnable;
    logic        memoryWriteEnable;
    logic        rdSource;
    logic [4:0]  rdAddr;
    logic [2:0]  funct3;
    logic [31:0] aluResult;
    logic [31:0] storeData;

    modport execute (output rdWriteEnable, memoryWriteEnable, rdSource, rdAddr, funct3,
                     aluResult, storeData);
    modport memory (input rdWriteEnable, memoryWriteEnable, rdSource, rdAddr, funct3,
                    aluResult, storeData);
endinterface

// File: rtl/jzjpcc_alu.sv
// Combinational RV32I ALU; op is the funct3 encoding, mod selects sub/sra.
module jzjpcc_alu
    import jzjpcc_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  aluOp_t      op,
    input  logic        mod,
    output logic [31:0] result
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (op)
            ADD:  result = mod ? (a - b) : (a + b);
            SLL:  result = a << shamt;
            SLT:  result = {31'd0, $signed(a) < $signed(b)};
            SLTU: result = {31'd0, a < b};
            XOR:  result = a ^ b;
            SRL:  result = mod ? $unsigned($signed(a) >>> shamt) : (a >> shamt);
            OR:   result = a | b;
            AND:  result = a & b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/jzjpcc_execute.sv
// Execute stage: operand forwarding, ALU, and the execute->memory pipeline register.
module jzjpcc_execute
    import jzjpcc_pkg::*;
#(
    parameter int PC_MAX_B = 15
) (
    input  logic                   clock,
    input  logic                   reset,
    jzjpcc_execute_if.execute      executeIF,
    jzjpcc_memory_if.execute       memoryIF,
    input  logic                   rdWriteEnable_writeback,
    input  logic [4:0]             rdAddr_writeback,
    input  logic [31:0]            rdData_writeback,
    input  logic                   flush_memory
);

    exMem_t      mem_q, mem_d;
    logic [31:0] rs1f, rs2f;
    logic [31:0] opA, opB;
    logic [31:0] aluOut;
    logic        aluModEff;
    aluOp_t      aluOp;
    aluMuxMode_t muxMode;

    assign aluOp   = aluOp_t'(executeIF.aluOperation);
    assign muxMode = aluMuxMode_t'(executeIF.aluMuxMode);

    assign rs1f = fwd_sel(executeIF.rs1Addr, executeIF.rs1,
                          mem_q.rdWriteEnable, mem_q.rdAddr, mem_q.rdSource, mem_q.aluResult,
                          rdWriteEnable_writeback, rdAddr_writeback, rdData_writeback);
    assign rs2f = fwd_sel(executeIF.rs2Addr, executeIF.rs2,
                          mem_q.rdWriteEnable, mem_q.rdAddr, mem_q.rdSource, mem_q.aluResult,
                          rdWriteEnable_writeback, rdAddr_writeback, rdData_writeback);

    always_comb begin
        opA = rs1f;
        opB = executeIF.imm;
        case (muxMode)
            RS1_RS2:  begin opA = rs1f; opB = rs2f; end
            RS1_IMM:  opA = rs1f;
            PC_IMM:   opA = 32'({executeIF.currentPC[PC_MAX_B:2], 2'b00});
            ZERO_IMM: opA = '0;
            default:  opA = rs1f;
        endcase
    end

    // aluMod means sub only for register-register add (addi has no sub form); sra always.
    assign aluModEff = executeIF.aluMod & ((aluOp != ADD) | (muxMode == RS1_RS2));

    jzjpcc_alu u_alu (
        .a      (opA),
        .b      (opB),
        .op     (aluOp),
        .mod    (aluModEff),
        .result (aluOut)
    );

    always_comb begin
        mem_d.rdWriteEnable     = executeIF.rdWriteEnable & ~flush_memory;
        mem_d.memoryWriteEnable = executeIF.memoryWriteEnable & ~flush_memory;
        mem_d.rdSource          = executeIF.rdSource;
        mem_d.rdAddr            = executeIF.rdAddr;
        mem_d.funct3            = executeIF.funct3;
        mem_d.aluResult         = aluOut;
        mem_d.storeData         = rs2f;
    end

    always_ff @(posedge clock) begin
        if (reset)
            mem_q <= '0;
        else
            mem_q <= mem_d;
    end

    assign memoryIF.rdWriteEnable     = mem_q.rdWriteEnable;
    assign memoryIF.memoryWriteEnable = mem_q.memoryWriteEnable;
    assign memoryIF.rdSource          = mem_q.rdSource;
    assign memoryIF.rdAddr            = mem_q.rdAddr;
    assign memoryIF.funct3            = mem_q.funct3;
    assign memoryIF.aluResult         = mem_q.aluResult;
    assign memoryIF.storeData         = mem_q.storeData;

endmodule

// File: tb/tb_jzjpcc_execute.sv
// Directed self-checking bench for the jzjpcc execute stage.
module tb_jzjpcc_execute;

    logic        clock = 1'b0;
    logic        reset;
    logic        rdWriteEnable_writeback;
    logic [4:0]  rdAddr_writeback;
    logic [31:0] rdData_writeback;
    logic        flush_memory;

    int tests = 0;
    int failures = 0;

    jzjpcc_execute_if #(.PC_MAX_B(15)) eif ();
    jzjpcc_memory_if mif ();

    jzjpcc_execute #(.PC_MAX_B(15)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .executeIF               (eif),
        .memoryIF                (mif),
        .rdWriteEnable_writeback (rdWriteEnable_writeback),
        .rdAddr_writeback        (rdAddr_writeback),
        .rdData_writeback        (rdData_writeback),
        .flush_memory            (flush_memory)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs1a, input logic [4:0] rs2a,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                         input logic [1:0] mux, input logic [2:0] op, input logic md,
                         input logic [4:0] rd, input logic we, input logic mwe, input logic src);
        eif.rs1Addr = rs1a;  eif.rs2Addr = rs2a;
        eif.rs1 = r1;        eif.rs2 = r2;       eif.imm = im;
        eif.aluMuxMode = mux; eif.aluOperation = op; eif.aluMod = md;
        eif.funct3 = op;     eif.rdAddr = rd;
        eif.rdWriteEnable = we; eif.memoryWriteEnable = mwe; eif.rdSource = src;
    endtask

    task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
        rdWriteEnable_writeback = we; rdAddr_writeback = rd; rdData_writeback = d;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".rdWE"},  {31'd0, mif.rdWriteEnable}, 32'd0);
        check({tag, ".memWE"}, {31'd0, mif.memoryWriteEnable}, 32'd0);
        check({tag, ".src"},   {31'd0, mif.rdSource}, 32'd0);
        check({tag, ".rdAddr"}, {27'd0, mif.rdAddr}, 32'd0);
        check({tag, ".funct3"}, {29'd0, mif.funct3}, 32'd0);
        check({tag, ".alu"},   mif.aluResult, 32'd0);
        check({tag, ".store"}, mif.storeData, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        flush_memory = 1'b0;
        eif.currentPC = '0;
        wb(1'b0, 5'd0, 32'd0);
        // valid instruction present during reset
        issue(5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 2'b00, 3'b000, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        check_all_zero("reset");

        // first post-reset edge loads: add x3 = 5 + 7
        reset = 1'b0;
        issue(5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 2'b00, 3'b000, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        check("add.alu", mif.aluResult, 32'd12);
        check("add.rdWE", {31'd0, mif.rdWriteEnable}, 32'd1);
        check("add.rdAddr", {27'd0, mif.rdAddr}, 32'd3);
        check("add.store", mif.storeData, 32'd7);

        issue(5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 2'b00, 3'b000, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        check("sub", mif.aluResult, 32'hFFFF_FFFE);

        issue(5'd1, 5'd2, 32'h7FFF_FFFF, 32'd1, 32'd0, 2'b00, 3'b000, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        check("add.wrap", mif.aluResult, 32'h8000_0000);

        // addi with aluMod set stays an add
        issue(5'd1, 5'd2, 32'd10, 32'd0, 32'd3, 2'b01, 3'b000, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        tick();
        check("addi.mod", mif.aluResult, 32'd13);

        issue(5'd1, 5'd2, 32'h8000_0010, 32'd0, 32'd4, 2'b01, 3'b101, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        tick();
        check("srai", mif.aluResult, 32'hF800_0001);
        check("srai.funct3", {29'd0, mif.funct3}, 32'd5);

        issue(5'd1, 5'd2, 32'h8000_0010, 32'd0, 32'd4, 2'b01, 3'b101, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        tick();
        check("srli", mif.aluResult, 32'h0800_0001);

        issue(5'd1, 5'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 2'b00, 3'b010, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        tick();
        check("slt", mif.aluResult, 32'd1);

        issue(5'd1, 5'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 2'b00, 3'b011, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        tick();
        check("sltu", mif.aluResult, 32'd0);

        // x5 = 0xAA lands in memory stage
        issue(5'd1, 5'd2, 32'hAA, 32'd0, 32'd0, 2'b01, 3'b000, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        check("x5.alu", mif.aluResult, 32'hAA);

        // memory x5=0xAA beats writeback x5=0xBB on both operands
        wb(1'b1, 5'd5, 32'hBB);
        issue(5'd5, 5'd5, 32'h11, 32'h22, 32'd0, 2'b00, 3'b000, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        tick();
        check("fwd.mem.alu", mif.aluResult, 32'h154);
        check("fwd.mem.store", mif.storeData, 32'hAA);

        // memory now holds x6; x5 only from writeback
        issue(5'd5, 5'd0, 32'h11, 32'h3, 32'd0, 2'b00, 3'b000, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        check("fwd.wb", mif.aluResult, 32'hBE);

        // writeback to x0 is ignored; this instruction itself "writes" x0
        wb(1'b1, 5'd0, 32'hBB);
        issue(5'd0, 5'd0, 32'h22, 32'h1, 32'd0, 2'b00, 3'b000, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        check("x0.wb", mif.aluResult, 32'h23);

        // memory holds x0=0x23 with write enable: still no forward
        wb(1'b0, 5'd0, 32'd0);
        issue(5'd0, 5'd0, 32'h1, 32'h2, 32'd0, 2'b00, 3'b000, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        tick();
        check("x0.mem", mif.aluResult, 32'h3);

        // unflushed store
        issue(5'd1, 5'd2, 32'h100, 32'h5A, 32'h4, 2'b01, 3'b010, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        eif.aluOperation = 3'b000;
        tick();
        check("store.memWE", {31'd0, mif.memoryWriteEnable}, 32'd1);
        check("store.data", mif.storeData, 32'h5A);
        check("store.addr", mif.aluResult, 32'h104);

        // flushed store that also claims x9
        flush_memory = 1'b1;
        issue(5'd1, 5'd2, 32'h50, 32'h1, 32'd0, 2'b01, 3'b000, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
        tick();
        check("flush.rdWE", {31'd0, mif.rdWriteEnable}, 32'd0);
        check("flush.memWE", {31'd0, mif.memoryWriteEnable}, 32'd0);

        flush_memory = 1'b0;
        issue(5'd9, 5'd2, 32'h7, 32'h0, 32'd0, 2'b01, 3'b000, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
        tick();
        check("flush.nofwd", mif.aluResult, 32'h7);

        eif.currentPC = 14'h40;
        issue(5'd1, 5'd2, 32'hDEAD, 32'h0, 32'h1000, 2'b10, 3'b000, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
        tick();
        check("auipc", mif.aluResult, 32'h1100);

        issue(5'd1, 5'd2, 32'hDEAD, 32'h0, 32'hABCD_E000, 2'b11, 3'b000, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
        tick();
        check("lui", mif.aluResult, 32'hABCD_E000);

        // load to x12: address computed, marked memory-sourced
        issue(5'd1, 5'd2, 32'h200, 32'h0, 32'h4, 2'b01, 3'b000, 1'b0, 5'd12, 1'b1, 1'b0, 1'b1);
        tick();
        check("load.src", {31'd0, mif.rdSource}, 32'd1);
        check("load.addr", mif.aluResult, 32'h204);

        issue(5'd12, 5'd2, 32'h99, 32'h0, 32'd0, 2'b01, 3'b000, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0);
        tick();
        check("load.nofwd", mif.aluResult, 32'h99);

        // bubble in execute writing x14 must not forward
        issue(5'd1, 5'd2, 32'h55, 32'h0, 32'd0, 2'b01, 3'b000, 1'b0, 5'd14, 1'b0, 1'b0, 1'b0);
        tick();
        check("bubble.rdWE", {31'd0, mif.rdWriteEnable}, 32'd0);

        issue(5'd14, 5'd2, 32'h66, 32'h0, 32'd0, 2'b01, 3'b000, 1'b0, 5'd15, 1'b1, 1'b1, 1'b0);
        tick();
        check("bubble.nofwd", mif.aluResult, 32'h66);

        // mid-stream reset with flush asserted
        reset = 1'b1;
        flush_memory = 1'b1;
        tick();
        check_all_zero("reset2");

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
